seq_shift_add_mult: RTL and testbench

- Parametrised, clocked successor to the team's combinational 8x8 shift-and-add multiplier.
- Computes a WIDTH x WIDTH product iteratively, one multiplier bit per clock, under a start/done handshake.
- Adds a per-operation signed (two's-complement) mode and a busy indication.
- Sits in the datapath wherever a compact, low-area multiplier is acceptable in exchange for WIDTH+1 cycles of latency.

---
 rtl/mult_pkg.sv | 15 +
 rtl/shift_add_step.sv | 22 ++
 rtl/seq_shift_add_mult.sv | 111 +++++++++++
 tb/tb_seq_shift_add_mult.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } mult_state_t;

  // Iteration counter must be able to hold the value WIDTH.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/shift_add_step.sv
// One shift-and-add iteration: conditional add of the multiplicand into the
// upper half, then a one-bit right shift of {carry, hi, lo}.
module shift_add_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   mcand_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] sum;

  // Add on lo[0], keep the carry, shift the whole accumulator right.
  always_comb begin
    sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]};
    if (acc_i[0]) begin
      sum = sum + {1'b0, mcand_i};
    end
    acc_o = {sum, acc_i[WIDTH-1:1]};
  end

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential WIDTH x WIDTH shift-and-add multiplier with start/done handshake,
// optional two's-complement mode (sign-magnitude internally) and busy flag.
module seq_shift_add_mult
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = cnt_width(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   multiplicand,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);

  mult_state_t        state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               neg_q, neg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   mplier_mag;
  logic [WIDTH-1:0]   mcand_mag;
  logic [2*WIDTH-1:0] acc_step;

  shift_add_step #(.WIDTH(WIDTH)) u_step (
    .acc_i   (acc_q),
    .mcand_i (mcand_q),
    .acc_o   (acc_step)
  );

  // Operand magnitudes; -2^(WIDTH-1) negates to itself, which reads back as
  // the correct unsigned magnitude.
  always_comb begin
    mplier_mag = (signed_mode && multiplier[WIDTH-1])   ? -multiplier   : multiplier;
    mcand_mag  = (signed_mode && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    neg_d     = neg_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          acc_d   = {{WIDTH{1'b0}}, mplier_mag};
          mcand_d = mcand_mag;
          neg_d   = signed_mode & (multiplier[WIDTH-1] ^ multiplicand[WIDTH-1]);
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        product_d = neg_q ? -acc_q : acc_q;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      neg_q     <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      neg_q     <= neg_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign product = product_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Bench for seq_shift_add_mult: WIDTH=8 instance checked every cycle against
// a transaction-level model, plus WIDTH=4 and WIDTH=16 instances checked per
// operation for result and latency.
module tb_seq_shift_add_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  // WIDTH=8 DUT
  logic        start8, sm8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  // WIDTH=4 DUT
  logic        start4, sm4, busy4, done4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;
  // WIDTH=16 DUT
  logic        start16, sm16, busy16, done16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  seq_shift_add_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .multiplier(a8), .multiplicand(b8), .product(p8), .busy(busy8), .done(done8));
  seq_shift_add_mult #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
    .multiplier(a4), .multiplicand(b4), .product(p4), .busy(busy4), .done(done4));
  seq_shift_add_mult #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
    .multiplier(a16), .multiplicand(b16), .product(p16), .busy(busy16), .done(done16));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference product, truncated to 2*w bits.
  function automatic logic [63:0] ref_mult(input int w, input logic [31:0] a,
                                           input logic [31:0] b, input logic sm);
    longint x, y, p;
    logic [63:0] mask;
    x = {32'd0, a};
    y = {32'd0, b};
    if (sm && a[w-1]) x = x - (longint'(1) << w);
    if (sm && b[w-1]) y = y - (longint'(1) << w);
    p = x * y;
    mask = (64'd1 << (2 * w)) - 64'd1;
    return 64'(p) & mask;
  endfunction

  // Transaction-level model of the WIDTH=8 instance.
  bit          chk_en = 1'b0;
  bit          m_busy, m_done;
  int          m_left;
  logic [15:0] m_prod, m_pend;
  logic [63:0] m_tmp;

  always @(posedge clk) begin
    if (rst) begin
      chk_en = 1'b1;
      m_busy = 1'b0; m_done = 1'b0; m_left = 0; m_prod = '0; m_pend = '0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0; m_done = 1'b1; m_prod = m_pend;
        end
      end else if (start8) begin
        m_busy = 1'b1;
        m_left = 9;
        m_tmp  = ref_mult(8, 32'(a8), 32'(b8), sm8);
        m_pend = m_tmp[15:0];
      end
    end
  end

  // Per-cycle comparison of the WIDTH=8 instance against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy8", 64'(busy8), 64'(m_busy));
      check("done8", 64'(done8), 64'(m_done));
      check("product8", 64'(p8), 64'(m_prod));
    end
  end

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                      output logic [15:0] p, output int lat, output int bcnt);
    @(negedge clk); a8 = a; b8 = b; sm8 = sm; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
    lat = 0; bcnt = 0;
    while (!done8 && lat < 40) begin
      if (busy8) bcnt++;
      @(negedge clk); lat++;
    end
    p = p8;
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic sm,
                      output logic [7:0] p, output int lat);
    @(negedge clk); a4 = a; b4 = b; sm4 = sm; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    lat = 0;
    while (!done4 && lat < 40) begin @(negedge clk); lat++; end
    p = p4;
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic sm,
                       output logic [31:0] p, output int lat);
    @(negedge clk); a16 = a; b16 = b; sm16 = sm; start16 = 1'b1;
    @(negedge clk); start16 = 1'b0;
    lat = 0;
    while (!done16 && lat < 60) begin @(negedge clk); lat++; end
    p = p16;
  endtask

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] p8r;
    logic [7:0]  p4r;
    logic [31:0] p16r;
    logic [7:0]  ra, rb;
    logic [3:0]  ra4, rb4;
    logic [15:0] ra16, rb16;
    logic        rs;
    int          lat, bcnt, ndone;

    rst = 1'b1;
    start8 = 0; sm8 = 0; a8 = '0; b8 = '0;
    start4 = 0; sm4 = 0; a4 = '0; b4 = '0;
    start16 = 0; sm16 = 0; a16 = '0; b16 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_p4", 64'(p4), 64'd0);
    check("reset_busy4", 64'(busy4), 64'd0);
    check("reset_p16", 64'(p16), 64'd0);
    check("reset_done16", 64'(done16), 64'd0);

    // Directed WIDTH=8 cases with hand-computed results
    run8(8'd13, 8'd11, 1'b0, p8r, lat, bcnt);
    check("u13x11", 64'(p8r), 64'd143);
    check("u13x11_lat", 64'(lat), 64'd9);
    check("u13x11_busy", 64'(bcnt), 64'd9);
    run8(8'd255, 8'd255, 1'b0, p8r, lat, bcnt);
    check("u255x255", 64'(p8r), 64'hFE01);
    run8(8'd0, 8'd200, 1'b0, p8r, lat, bcnt);
    check("u0x200", 64'(p8r), 64'd0);
    check("u0x200_lat", 64'(lat), 64'd9);
    run8(8'hFD, 8'd7, 1'b1, p8r, lat, bcnt);
    check("s-3x7", 64'(p8r), 64'hFFEB);
    run8(8'h80, 8'h80, 1'b1, p8r, lat, bcnt);
    check("s-128x-128", 64'(p8r), 64'h4000);
    run8(8'h80, 8'h01, 1'b1, p8r, lat, bcnt);
    check("s-128x1", 64'(p8r), 64'hFF80);
    run8(8'h00, 8'h80, 1'b1, p8r, lat, bcnt);
    check("s0x-128", 64'(p8r), 64'd0);

    // Handshake: starts while busy ignored, start in done cycle accepted
    @(negedge clk); a8 = 8'd13; b8 = 8'd11; sm8 = 1'b0; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 40) begin
      @(negedge clk); lat++;
      if (lat == 1 || lat == 4) begin start8 = 1'b1; a8 = 8'd1; b8 = 8'd1; end
      else start8 = 1'b0;
    end
    check("hs_first_lat", 64'(lat), 64'd9);
    check("hs_first_p", 64'(p8), 64'd143);
    a8 = 8'd2; b8 = 8'd3; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    check("hs_hold_p", 64'(p8), 64'd143);
    check("hs_busy", 64'(busy8), 64'd1);
    lat = 0;
    while (!done8 && lat < 40) begin @(negedge clk); lat++; end
    check("hs_second_lat", 64'(lat), 64'd9);
    check("hs_second_p", 64'(p8), 64'd6);

    // Reset mid-operation
    @(negedge clk); a8 = 8'd100; b8 = 8'd100; sm8 = 1'b0; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("rst_p", 64'(p8), 64'd0);
    check("rst_busy", 64'(busy8), 64'd0);
    check("rst_done", 64'(done8), 64'd0);
    ndone = 0;
    repeat (20) begin @(negedge clk); if (done8) ndone++; end
    check("rst_no_done", 64'(ndone), 64'd0);
    run8(8'd5, 8'd5, 1'b0, p8r, lat, bcnt);
    check("after_rst_5x5", 64'(p8r), 64'd25);

    // Random WIDTH=8 regression, both modes
    repeat (60) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      run8(ra, rb, rs, p8r, lat, bcnt);
      check("rnd8", 64'(p8r), ref_mult(8, 32'(ra), 32'(rb), rs));
      check("rnd8_lat", 64'(lat), 64'd9);
    end

    // WIDTH=4
    run4(4'h8, 4'd7, 1'b1, p4r, lat);
    check("w4_s-8x7", 64'(p4r), 64'hC8);
    check("w4_lat", 64'(lat), 64'd5);
    repeat (20) begin
      ra4 = 4'($urandom); rb4 = 4'($urandom); rs = 1'($urandom);
      run4(ra4, rb4, rs, p4r, lat);
      check("rnd4", 64'(p4r), ref_mult(4, 32'(ra4), 32'(rb4), rs));
      check("rnd4_lat", 64'(lat), 64'd5);
    end

    // WIDTH=16
    run16(16'hFFFF, 16'hFFFF, 1'b0, p16r, lat);
    check("w16_max", 64'(p16r), 64'hFFFE0001);
    check("w16_lat", 64'(lat), 64'd17);
    run16(16'h8000, 16'h8000, 1'b1, p16r, lat);
    check("w16_s_min_sq", 64'(p16r), 64'h40000000);
    repeat (20) begin
      ra16 = 16'($urandom); rb16 = 16'($urandom); rs = 1'($urandom);
      run16(ra16, rb16, rs, p16r, lat);
      check("rnd16", 64'(p16r), ref_mult(16, 32'(ra16), 32'(rb16), rs));
      check("rnd16_lat", 64'(lat), 64'd17);
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
